// File: rtl/obj_bbox_centroid.sv
// rtl/obj_bbox_centroid.sv - per-frame bounding box, pixel count and centroid of a binary object mask
//
// Purpose:
//   Accumulates bounding box, set-pixel count and coordinate sums of the
//   1-bit object mask over each frame. At frame end (first blanking line)
//   it divides the sums by the count with a shared restoring divider, one
//   quotient bit per cycle, and publishes one result set per frame.
//
// Ports:
//   PCLK       in   pixel clock, rising edge
//   RST        in   synchronous active-high reset
//   VtcHCnt    in   horizontal counter, aligned with pix_i
//   VtcVCnt    in   vertical counter, aligned with pix_i
//   pix_i      in   mask pixel, 1 = object
//   x_min/x_max/y_min/y_max  out  bounding box of set pixels
//   cx/cy      out  floor(sum/count) centroid
//   pix_count  out  set-pixel count of the last frame
//   obj_found  out  last published count >= MIN_PIXELS
//   valid      out  one-cycle pulse when outputs update
module obj_bbox_centroid #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        PCLK,
  input  logic        RST,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic        pix_i,
  output logic [11:0] x_min,
  output logic [11:0] x_max,
  output logic [11:0] y_min,
  output logic [11:0] y_max,
  output logic [11:0] cx,
  output logic [11:0] cy,
  output logic [18:0] pix_count,
  output logic        obj_found,
  output logic        valid
);

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);
  localparam logic [18:0] MIN_P = 19'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} state_t;

  state_t      state;
  logic        armed;
  logic [4:0]  step;

  // running accumulators
  logic [11:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic [18:0] cnt_r;
  logic [27:0] sx_r, sy_r;

  // frame snapshot taken at frame end
  logic [11:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic [18:0] snap_cnt;
  logic [27:0] snap_sy;

  // divider datapath
  logic [27:0] num;
  logic [18:0] rem;
  logic [11:0] quo;
  logic [11:0] qx;

  logic        active, fs, fe, fe_go, hit;
  logic [11:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic [18:0] b_cnt;
  logic [27:0] b_sx, b_sy;
  logic [11:0] n_xmin, n_xmax, n_ymin, n_ymax;
  logic [18:0] n_cnt;
  logic [27:0] n_sx, n_sy;
  logic [19:0] sh;
  logic        ge;
  logic [11:0] q_next;

  always_comb begin
    active = (VtcHCnt < H_LIM) && (VtcVCnt < V_LIM);
    fs     = (VtcHCnt == 12'd0) && (VtcVCnt == 12'd0);
    fe     = (VtcHCnt == 12'd0) && (VtcVCnt == V_LIM);
    fe_go  = fe && armed && (state == IDLE);
    // the FS pixel counts against the freshly cleared accumulators
    hit    = (armed || fs) && active && pix_i;

    b_xmin = fs ? 12'hFFF : xmin_r;
    b_ymin = fs ? 12'hFFF : ymin_r;
    b_xmax = fs ? 12'd0   : xmax_r;
    b_ymax = fs ? 12'd0   : ymax_r;
    b_cnt  = fs ? 19'd0   : cnt_r;
    b_sx   = fs ? 28'd0   : sx_r;
    b_sy   = fs ? 28'd0   : sy_r;

    n_xmin = (hit && (VtcHCnt < b_xmin)) ? VtcHCnt : b_xmin;
    n_xmax = (hit && (VtcHCnt > b_xmax)) ? VtcHCnt : b_xmax;
    n_ymin = (hit && (VtcVCnt < b_ymin)) ? VtcVCnt : b_ymin;
    n_ymax = (hit && (VtcVCnt > b_ymax)) ? VtcVCnt : b_ymax;
    n_cnt  = hit ? b_cnt + 19'd1 : b_cnt;
    n_sx   = hit ? b_sx + {16'd0, VtcHCnt} : b_sx;
    n_sy   = hit ? b_sy + {16'd0, VtcVCnt} : b_sy;

    // restoring step: remainder stays below the divisor, so 19 bits hold it
    // and the 19-bit subtraction below is exact whenever ge is set
    sh     = {rem, num[27]};
    ge     = (sh >= {1'b0, snap_cnt});
    q_next = {quo[10:0], ge};
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      armed  <= 1'b0;
      xmin_r <= 12'd0;
      xmax_r <= 12'd0;
      ymin_r <= 12'd0;
      ymax_r <= 12'd0;
      cnt_r  <= 19'd0;
      sx_r   <= 28'd0;
      sy_r   <= 28'd0;
    end else begin
      xmin_r <= n_xmin;
      xmax_r <= n_xmax;
      ymin_r <= n_ymin;
      ymax_r <= n_ymax;
      cnt_r  <= n_cnt;
      sx_r   <= n_sx;
      sy_r   <= n_sy;
      if (fs)
        armed <= 1'b1;
      else if (fe_go)
        armed <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      state     <= IDLE;
      step      <= 5'd0;
      num       <= 28'd0;
      rem       <= 19'd0;
      quo       <= 12'd0;
      qx        <= 12'd0;
      snap_xmin <= 12'd0;
      snap_xmax <= 12'd0;
      snap_ymin <= 12'd0;
      snap_ymax <= 12'd0;
      snap_cnt  <= 19'd0;
      snap_sy   <= 28'd0;
      x_min     <= 12'd0;
      x_max     <= 12'd0;
      y_min     <= 12'd0;
      y_max     <= 12'd0;
      cx        <= 12'd0;
      cy        <= 12'd0;
      pix_count <= 19'd0;
      obj_found <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (fs && (state != IDLE)) begin
        // frame start arrived before the divide finished: drop this result
        state <= IDLE;
        step  <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (fe_go) begin
              snap_xmin <= xmin_r;
              snap_xmax <= xmax_r;
              snap_ymin <= ymin_r;
              snap_ymax <= ymax_r;
              snap_cnt  <= cnt_r;
              snap_sy   <= sy_r;
              num       <= sx_r;
              rem       <= 19'd0;
              step      <= 5'd0;
              state     <= DIV_X;
            end
          end
          DIV_X, DIV_Y: begin
            num <= num << 1;
            rem <= ge ? (sh[18:0] - snap_cnt) : sh[18:0];
            quo <= q_next;
            if (step == 5'd27) begin
              step <= 5'd0;
              if (state == DIV_X) begin
                qx    <= q_next;
                num   <= snap_sy;
                rem   <= 19'd0;
                state <= DIV_Y;
              end else begin
                state <= PUBLISH;
              end
            end else begin
              step <= step + 5'd1;
            end
          end
          PUBLISH: begin
            pix_count <= snap_cnt;
            valid     <= 1'b1;
            if (snap_cnt >= MIN_P) begin
              obj_found <= 1'b1;
              x_min     <= snap_xmin;
              x_max     <= snap_xmax;
              y_min     <= snap_ymin;
              y_max     <= snap_ymax;
              cx        <= qx;
              cy        <= quo;
            end else begin
              // too few pixels: divider result (possibly divide-by-zero) is discarded
              obj_found <= 1'b0;
              x_min     <= 12'd0;
              x_max     <= 12'd0;
              y_min     <= 12'd0;
              y_max     <= 12'd0;
              cx        <= 12'd0;
              cy        <= 12'd0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obj_bbox_centroid.sv
// tb/tb_obj_bbox_centroid.sv - directed self-checking bench for obj_bbox_centroid
module tb_obj_bbox_centroid;

  localparam int HA = 128;
  localparam int VA = 56;
  localparam int HB = 4;

  logic        PCLK = 1'b0;
  logic        RST;
  logic [11:0] VtcHCnt, VtcVCnt;
  logic        pix_i;
  logic [11:0] x_min, x_max, y_min, y_max, cx, cy;
  logic [18:0] pix_count;
  logic        obj_found, valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int valid_cyc = -1;
  int fe_cyc = 0;

  obj_bbox_centroid #(.H_ACTIVE(HA), .V_ACTIVE(VA), .MIN_PIXELS(16)) dut (
    .PCLK(PCLK), .RST(RST), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt), .pix_i(pix_i),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .cx(cx), .cy(cy), .pix_count(pix_count), .obj_found(obj_found), .valid(valid)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (valid === 1'b1) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int exmn, input int exmx, input int eymn, input int eymx,
                            input int ecx, input int ecy, input int ecnt, input int efound);
    check("x_min", 32'(x_min), 32'(exmn));
    check("x_max", 32'(x_max), 32'(exmx));
    check("y_min", 32'(y_min), 32'(eymn));
    check("y_max", 32'(y_max), 32'(eymx));
    check("cx", 32'(cx), 32'(ecx));
    check("cy", 32'(cy), 32'(ecy));
    check("pix_count", 32'(pix_count), 32'(ecnt));
    check("obj_found", 32'(obj_found), 32'(efound));
  endtask

  function automatic logic pix_of(input int kind, input int h, input int v);
    case (kind)
      1:       return (h >= 100 && h <= 103 && v >= 50 && v <= 53);
      2:       return (h >= 100 && h <= 103 && v >= 50 && v <= 53) && !(h == 103 && v == 53);
      3:       return 1'b1;
      4:       return (h >= HA) || (v >= VA);
      5:       return (h >= 10 && h <= 17 && v >= 20 && v <= 21);
      default: return 1'b0;
    endcase
  endfunction

  // Drives lines 0..VA-1 plus the first blanking line (FE at its h=0).
  task automatic run_frame(input int kind, input int rst_lo, input int rst_hi,
                           input int exp_valid, input int hold_chk);
    int nv0;
    nv0 = n_valid;
    for (int v = 0; v <= VA; v++) begin
      for (int h = 0; h < HA + HB; h++) begin
        @(negedge PCLK);
        if (hold_chk != 0 && v == VA && h == 57) begin
          check("hold_valid", 32'(valid), 32'd0);
          check("hold_x_min", 32'(x_min), 32'd100);
          check("hold_cx", 32'(cx), 32'd101);
        end
        if (v == VA && h == 0) fe_cyc = cyc;
        RST     = (v >= rst_lo && v < rst_hi);
        VtcHCnt = 12'(h);
        VtcVCnt = 12'(v);
        pix_i   = pix_of(kind, h, v);
      end
    end
    @(negedge PCLK);
    #1;
    check("valid_pulses", 32'(n_valid - nv0), 32'(exp_valid));
    if (exp_valid != 0) check("latency", 32'(valid_cyc - fe_cyc), 32'd58);
  endtask

  initial begin
    RST     = 1'b1;
    VtcHCnt = 12'(HA + 1);
    VtcVCnt = 12'(VA + 1);
    pix_i   = 1'b1;
    repeat (4) @(negedge PCLK);
    RST = 1'b0;
    @(negedge PCLK);
    expect_out(0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_valid", 32'(valid), 32'd0);

    // 4x4 block
    run_frame(1, -1, -1, 1, 0);
    expect_out(100, 103, 50, 53, 101, 51, 16, 1);

    // 15 pixels, below threshold
    run_frame(2, -1, -1, 1, 0);
    expect_out(0, 0, 0, 0, 0, 0, 15, 0);

    // empty frame
    run_frame(0, -1, -1, 1, 0);
    expect_out(0, 0, 0, 0, 0, 0, 0, 0);

    // ones only in blanking
    run_frame(4, -1, -1, 1, 0);
    expect_out(0, 0, 0, 0, 0, 0, 0, 0);

    // all-ones frame
    run_frame(3, -1, -1, 1, 0);
    expect_out(0, HA - 1, 0, VA - 1, 63, 27, HA * VA, 1);

    // reset mid-frame: no publish, outputs cleared
    run_frame(1, 20, 25, 0, 0);
    expect_out(0, 0, 0, 0, 0, 0, 0, 0);

    // next complete frame publishes
    run_frame(1, -1, -1, 1, 0);
    expect_out(100, 103, 50, 53, 101, 51, 16, 1);

    // consecutive frame with a different object; frame-1 values held until T+58
    run_frame(5, -1, -1, 1, 1);
    expect_out(10, 17, 20, 21, 13, 20, 16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_bbox_centroid.md
Name: obj_bbox_centroid

Overview:
- Downstream of the binary morphology stage (dilation output).
- Consumes the cleaned 1-bit object mask together with the VTC counters.
- Accumulates the bounding box, pixel count and coordinate sums of all set pixels in each frame.
- In vertical blanking, computes the integer centroid with a sequential divider and publishes one result set per frame for the tracking/overlay logic.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- MIN_PIXELS, 16, minimum set-pixel count for a valid object.

Ports:
- PCLK  in  1  pixel clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- VtcHCnt  in  12  horizontal counter, aligned with pix_i.
- VtcVCnt  in  12  vertical counter, aligned with pix_i.
- pix_i  in  1  binary mask pixel, 1 = object.
- x_min  out  12  leftmost set-pixel column.
- x_max  out  12  rightmost set-pixel column.
- y_min  out  12  top set-pixel row.
- y_max  out  12  bottom set-pixel row.
- cx  out  12  centroid column, floor(sum_x/count).
- cy  out  12  centroid row, floor(sum_y/count).
- pix_count  out  19  set-pixel count of last frame.
- obj_found  out  1  last published frame had count >= MIN_PIXELS.
- valid  out  1  one-cycle pulse when outputs update.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; accumulators 0; armed=0.
- Active pixel: VtcHCnt < H_ACTIVE and VtcVCnt < V_ACTIVE. Counters are used as presented; this block applies no latency compensation.
- Frame start (FS): VtcVCnt==0 and VtcHCnt==0.
  - Sets armed=1.
  - Loads running min regs to 12'hFFF, max regs to 0, count/sums to 0.
  - The FS pixel itself is accumulated against these fresh values in the same cycle.
- Accumulate, when armed and active and pix_i==1:
  - count+=1 (19 b).
  - sum_x+=VtcHCnt (28 b).
  - sum_y+=VtcVCnt (28 b).
  - min/max compare-update.
  - Non-active pixels are ignored whatever pix_i is.
- Frame end trigger (FE): VtcVCnt==V_ACTIVE and VtcHCnt==0, while armed and FSM in IDLE. Call this cycle T.
  - If not armed (e.g. reset released mid-frame), FE is ignored and nothing is published.
- FSM states: IDLE -> DIV_X -> DIV_Y -> PUBLISH -> IDLE.
  - IDLE: accumulate; on FE, snapshot count/sums/bbox and clear armed.
  - DIV_X: cycles T+1..T+28. Restoring divide of sum_x by count, 28 iterations, one quotient bit per cycle.
  - DIV_Y: cycles T+29..T+56. Same divide for sum_y.
  - PUBLISH: cycle T+57. Registers the results and sets valid.
- Publish timing: outputs and valid change at the edge ending T+57. valid is high only in cycle T+58. Latency is fixed whatever the count.
- Count below MIN_PIXELS (including 0):
  - obj_found=0.
  - x_min/x_max/y_min/y_max/cx/cy forced to 0.
  - pix_count still reports the true count.
  - The divide-by-zero result is discarded; outputs must never show X.
- Count >= MIN_PIXELS:
  - obj_found=1.
  - Quotients are truncated to 12 b (always < 640 by construction).
- Between publishes, outputs hold the last frame's values.
- FS while FSM is not IDLE (illegal timing): abort the division, return to IDLE, no publish, start the new accumulation.
- RST at any time: immediate return to reset state. The in-progress frame is discarded; the first publish follows the next complete FS..FE frame.

Test Plan:
- 4x4 block of 1s at x 100..103, y 50..53, rest 0 -> valid at T+58 with x_min=100, x_max=103, y_min=50, y_max=53, pix_count=16, cx=101, cy=51, obj_found=1.
- 15 set pixels (MIN_PIXELS=16); separately, an all-zero frame -> valid pulses; obj_found=0; bbox/cx/cy=0; pix_count=15, then 0; no X on outputs.
- All-ones full frame -> x_min=0, x_max=639, y_min=0, y_max=479, pix_count=307200, cx=319, cy=239.
- pix_i=1 only at VtcHCnt 640..799 and on VtcVCnt>=480 lines -> pix_count=0, obj_found=0.
- Assert RST at line 200 of a frame with an object, release at line 210 -> no valid at that frame's FE; next full frame publishes correct values; outputs read 0 until then.
- Two consecutive frames with different objects -> exactly one valid per frame; outputs hold frame-1 values until frame-2 T+58.
